// File: rtl/pattern_serializer_fsm_pkg.sv
// Shared definitions for the pattern serializer.
//   - State codes for the IDLE/SEND/DONE controller (2-bit; code 3 is illegal).
//   - Default widths for the pattern, the length field and the repeat field.
//   - norm_len(): maps a requested length onto the number of bits actually sent.
package pattern_serializer_fsm_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_REP_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t DONE = 2'd2;

    // A length of 0, or anything longer than the pattern register, means
    // "send the whole register".
    function automatic int norm_len(input int len, input int width);
        if ((len == 0) || (len > width)) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/pattern_serializer_fsm_if.sv
// Load-side bus of the pattern serializer.
//   load_valid  : master -> slave, load request
//   load_ready  : slave -> master, serializer is idle and can take a pattern
//   load_data   : master -> slave, pattern word (bit [len-1] goes out first)
//   load_len    : master -> slave, bits per frame (0 or > WIDTH means WIDTH)
//   load_reps   : master -> slave, extra repetitions of the frame
// master = the agent supplying patterns, slave = the serializer.
interface pattern_serializer_fsm_if
    import pattern_serializer_fsm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic [REP_W-1:0] load_reps;

    modport master (
        output load_valid,
        output load_data,
        output load_len,
        output load_reps,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_len,
        input  load_reps,
        output load_ready
    );

endinterface

// File: rtl/pattern_serializer_fsm.sv
// Serial pattern transmitter. Takes a parallel pattern over the load bus and
// shifts it out MSB-first (bit [len-1] first) on x, repeating the frame
// load_reps extra times back-to-back with no gap cycle.
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset
//   ld           : load bus (slave side), see pattern_serializer_fsm_if
//   hold         : stalls transmission while high in SEND (no bit lost)
//   x            : serial data bit (registered)
//   x_valid      : x carries a new bit this cycle (registered)
//   frame_start  : first bit of each repetition (registered)
//   done         : one-cycle pulse together with the final bit (state decode)
module pattern_serializer_fsm
    import pattern_serializer_fsm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int REP_W = DEF_REP_W
) (
    input  logic                      clk,
    input  logic                      reset,
    pattern_serializer_fsm_if.slave   ld,
    input  logic                      hold,
    output logic                      x,
    output logic                      x_valid,
    output logic                      frame_start,
    output logic                      done
);

    // bit_idx and len share the LEN_W-bit field, so it must be able to hold WIDTH.
    if ((2 ** LEN_W) <= WIDTH) begin : g_bad_len_w
        $error("LEN_W too small to hold WIDTH");
    end

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             frame_start_q, frame_start_d;

    logic [LEN_W-1:0] len_norm;
    logic [WIDTH-1:0] pat_shift;
    logic             last_bit;

    assign len_norm  = LEN_W'(norm_len(int'(ld.load_len), WIDTH));
    // Shift instead of a variable bit-select so the index width never matters.
    assign pat_shift = pat_q >> bit_idx_q;
    // Final bit of the final repetition is being emitted on this edge.
    assign last_bit  = (bit_idx_q == '0) && (rep_cnt_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ld.load_valid) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!hold && last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        pat_d         = pat_q;
        len_d         = len_q;
        bit_idx_d     = bit_idx_q;
        rep_cnt_d     = rep_cnt_q;
        x_d           = x_q;
        x_valid_d     = x_valid_q;
        frame_start_d = frame_start_q;

        case (state_q)
            IDLE: begin
                x_d           = 1'b0;
                x_valid_d     = 1'b0;
                frame_start_d = 1'b0;
                if (ld.load_valid) begin
                    pat_d     = ld.load_data;
                    len_d     = len_norm;
                    rep_cnt_d = ld.load_reps;
                    bit_idx_d = len_norm - LEN_ONE;
                end
            end
            SEND: begin
                if (hold) begin
                    // Stall: x keeps its last value, counters are frozen.
                    x_valid_d     = 1'b0;
                    frame_start_d = 1'b0;
                end else begin
                    x_d           = pat_shift[0];
                    x_valid_d     = 1'b1;
                    frame_start_d = (bit_idx_q == (len_q - LEN_ONE));
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - LEN_ONE;
                    end else if (rep_cnt_q != '0) begin
                        // Wrap straight into the next repetition, no gap cycle.
                        rep_cnt_d = rep_cnt_q - REP_ONE;
                        bit_idx_d = len_q - LEN_ONE;
                    end
                end
            end
            DONE: begin
                x_d           = 1'b0;
                x_valid_d     = 1'b0;
                frame_start_d = 1'b0;
            end
            default: begin
                x_d           = 1'b0;
                x_valid_d     = 1'b0;
                frame_start_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q         <= '0;
            len_q         <= '0;
            bit_idx_q     <= '0;
            rep_cnt_q     <= '0;
            x_q           <= 1'b0;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pat_q         <= pat_d;
            len_q         <= len_d;
            bit_idx_q     <= bit_idx_d;
            rep_cnt_q     <= rep_cnt_d;
            x_q           <= x_d;
            x_valid_q     <= x_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ld.load_ready = (state_q == IDLE);
    assign done          = (state_q == DONE);
    assign x             = x_q;
    assign x_valid       = x_valid_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_pattern_serializer_fsm.sv
module tb_pattern_serializer_fsm;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;
    localparam int FRAME_BOUND = 2000;

    logic clk = 1'b0;
    logic reset;
    logic hold;
    logic x;
    logic x_valid;
    logic frame_start;
    logic done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pattern_serializer_fsm_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) ld_if ();

    pattern_serializer_fsm #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld          (ld_if),
        .hold        (hold),
        .x           (x),
        .x_valid     (x_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_load();
        ld_if.load_data = WIDTH'($urandom);
        ld_if.load_len  = LEN_W'($urandom);
        ld_if.load_reps = REP_W'($urandom);
    endtask

    // Must be called at a negedge while the serializer is idle. Builds the
    // expected bit stream from the load parameters, sends the load and
    // scoreboards every cycle until all bits have been seen, then checks the
    // cycle after done. hold_at>0 gives a directed stall of hold_len cycles
    // after bit hold_at; otherwise hold is random with hold_pct percent.
    task automatic run_frame(input logic [WIDTH-1:0] data, input int len, input int reps,
                             input int hold_pct, input int hold_at, input int hold_len,
                             input bit keep_valid);
        bit               exp_x[$];
        bit               exp_fs[$];
        logic [WIDTH-1:0] tmp;
        int               le, total, seen, hcnt, cyc;
        bit               last_x, hold_prev;

        le = ((len == 0) || (len > WIDTH)) ? WIDTH : len;
        for (int r = 0; r <= reps; r++) begin
            for (int i = le - 1; i >= 0; i--) begin
                tmp = data >> i;
                exp_x.push_back(tmp[0]);
                exp_fs.push_back(i == le - 1);
            end
        end
        total = exp_x.size();

        check("ready_before_load", ld_if.load_ready, 1);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = data;
        ld_if.load_len   = LEN_W'(len);
        ld_if.load_reps  = REP_W'(reps);
        hold             = 1'b0;
        @(negedge clk);
        // Accepted on the edge just passed; first bit only after the next one.
        check("latency_x_valid", x_valid, 0);
        check("latency_ready", ld_if.load_ready, 0);
        if (keep_valid) scramble_load();
        else ld_if.load_valid = 1'b0;

        seen   = 0;
        hcnt   = 0;
        cyc    = 0;
        last_x = 1'b0;
        if (hold_at == 0) hold = ($urandom_range(99) < hold_pct);

        while (exp_x.size() > 0 && cyc < FRAME_BOUND) begin
            hold_prev = hold;
            @(negedge clk);
            cyc++;
            check("x_valid", x_valid, !hold_prev);
            if (x_valid) begin
                check("x", x, exp_x[0]);
                check("frame_start", frame_start, exp_fs[0]);
                check("done", done, exp_x.size() == 1);
                last_x = x;
                void'(exp_x.pop_front());
                void'(exp_fs.pop_front());
                seen++;
            end else begin
                check("stall_done", done, 0);
                check("stall_fs", frame_start, 0);
                if (seen > 0) check("stall_x_held", x, last_x);
            end
            if (hold_at > 0) begin
                if (seen == hold_at && hcnt < hold_len) begin
                    hold = 1'b1;
                    hcnt++;
                end else begin
                    hold = 1'b0;
                end
            end else begin
                hold = ($urandom_range(99) < hold_pct);
            end
            if (keep_valid) scramble_load();
        end
        check("bits_sent", seen, total);

        @(negedge clk);
        hold = 1'b0;
        check("after_done_done", done, 0);
        check("after_done_x_valid", x_valid, 0);
        check("after_done_x", x, 0);
        check("after_done_ready", ld_if.load_ready, 1);
    endtask

    initial begin
        reset            = 1'b1;
        hold             = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.load_data  = '0;
        ld_if.load_len   = '0;
        ld_if.load_reps  = '0;

        // Reset takes effect before any clock edge.
        #1;
        check("rst_x", x, 0);
        check("rst_x_valid", x_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_done", done, 0);
        check("rst_ready", ld_if.load_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", ld_if.load_ready, 1);

        run_frame(8'h05, 3, 0, 0, 0, 0, 1'b0);
        run_frame(8'hA5, 0, 0, 0, 0, 0, 1'b0);
        run_frame(8'h05, 3, 2, 0, 0, 0, 1'b0);
        run_frame(8'h05, 3, 0, 0, 2, 2, 1'b0);

        // Asynchronous reset in the middle of an 8-bit frame.
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 8'hC3;
        ld_if.load_len   = LEN_W'(8);
        ld_if.load_reps  = '0;
        @(negedge clk);
        ld_if.load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_bit2_valid", x_valid, 1);
        check("midrst_bit2_x", x, 1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_x", x, 0);
        check("midrst_x_valid", x_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ld_if.load_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("postrst_done", done, 0);
        check("postrst_ready", ld_if.load_ready, 1);
        run_frame(8'hFF, 8, 0, 0, 0, 0, 1'b0);

        // load_valid held high with changing data: second word only after ready.
        run_frame(8'h3C, 6, 1, 0, 0, 0, 1'b1);
        run_frame(8'h96, 8, 0, 20, 0, 0, 1'b1);
        ld_if.load_valid = 1'b0;

        // Boundaries: one-bit frames, oversized length, maximum repeat count.
        run_frame(8'h01, 1, 5, 0, 0, 0, 1'b0);
        run_frame(8'h5A, 12, 0, 0, 0, 0, 1'b0);
        run_frame(8'h02, 2, 15, 0, 0, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            run_frame(WIDTH'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      30, 0, 0, bit'($urandom_range(0, 1)));
        end
        ld_if.load_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pattern_serializer_fsm.md
Name: pattern_serializer_fsm

Overview:
- Serial pattern transmitter: accepts a parallel pattern word over a valid/ready load handshake.
- Emits the pattern MSB-first on a 1-bit serial line, optionally repeated back-to-back, with a per-bit valid qualifier.
- Produces the single-bit x stream consumed by the team's serial sequence detectors; used as the on-chip stimulus/transmit end of that interface.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, 4, width of load_len; must satisfy 2**LEN_W > WIDTH.
- REP_W, 4, width of load_reps.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load request.
- load_ready  output  1  high only in IDLE; a load is accepted on a rising edge where load_valid and load_ready are both 1.
- load_data  input  WIDTH  pattern; bit [len-1] is sent first, bit 0 last.
- load_len  input  LEN_W  number of bits to send; 0 or any value above WIDTH means WIDTH.
- load_reps  input  REP_W  extra repetitions; total frames = load_reps+1.
- hold  input  1  stall request; freezes transmission while high in SEND.
- x  output  1  serial data bit, registered.
- x_valid  output  1  x carries a new bit this cycle, registered.
- frame_start  output  1  high with the first bit of each repetition, registered.
- done  output  1  high for exactly one cycle, coinciding with the final bit (Moore decode of DONE).

Behaviour:
- Reset values: state IDLE; x, x_valid, frame_start, done = 0; load_ready = 1. All internal registers (pattern, bit index, rep counter, len) are 0. Reset takes effect immediately, without waiting for a clock edge.
- State encoding: IDLE=0, SEND=1, DONE=2. Illegal state 3 returns to IDLE on the next edge with outputs cleared.
- Outputs: load_ready and done are decoded from state only. x, x_valid and frame_start are registers.

IDLE:
- On accept: capture load_data; set len_eff = normalized load_len; set rep_cnt = load_reps; set bit_idx = len_eff-1; go to SEND.
- x and x_valid remain 0.

SEND, each rising edge with hold=0:
- x <= pat[bit_idx]; x_valid <= 1; frame_start <= (bit_idx == len_eff-1).
- If bit_idx > 0: decrement bit_idx.
- Else if rep_cnt > 0: decrement rep_cnt; set bit_idx = len_eff-1. Frames are contiguous, with no gap cycle.
- Else: go to DONE.

SEND, each rising edge with hold=1:
- x_valid <= 0; frame_start <= 0; x keeps its value.
- bit_idx, rep_cnt and state are unchanged. Any hold length is legal.

DONE:
- done=1, and the final bit is visible on x with x_valid=1 in the same cycle.
- On the next edge: go to IDLE; x <= 0; x_valid <= 0; frame_start <= 0. hold is ignored in DONE.

Timing and counts:
- Latency: load accepted at edge N puts the first bit on x/x_valid in the cycle after edge N+1.
- A frame produces exactly len_eff*(load_reps+1) x_valid cycles; hold adds cycles but never adds or drops bits.
- Back-to-back: load_ready returns 1 in the cycle after DONE. The earliest next accept is therefore 2 edges after the final bit first appears.

Boundary conditions:
- load_valid while not IDLE is ignored; load_data and load_len changes do not affect the frame in flight.
- len_eff=1 yields one bit per frame; frame_start is then high on every valid bit.
- Maximum rep count (all ones) yields 2**REP_W frames.
- Reset asserted mid-frame abandons the frame: no done pulse, and outputs clear immediately.

Decomposition:
- Shared package holds:
  - state localparams IDLE/SEND/DONE;
  - default WIDTH/LEN_W/REP_W;
  - a length-normalization function (0 or >WIDTH -> WIDTH).
- Single module; no sub-module needed. Write it as a state register, a next-state always block and a datapath register block, all with asynchronous reset.

Test Plan:
- Reset, then load data=8'h05, len=3, reps=0 -> x_valid high for 3 cycles with x=1,0,1; frame_start on the first bit; done with the third bit; load_ready=1 one cycle later.
- Load data=8'hA5, len=0 -> 8 valid bits 1,0,1,0,0,1,0,1; done on the 8th bit.
- Load data=8'h05, len=3, reps=2 -> 9 contiguous valid bits 101101101; frame_start on bits 1, 4 and 7; a single done pulse.
- Load data=8'h05, len=3, hold high for 2 cycles right after bit 2 -> x_valid low for 2 cycles with x held at 0; bit 3 (x=1) follows; done is delayed by 2 cycles.
- Assert reset between edges during bit 2 of an 8-bit frame -> x, x_valid, done go to 0 immediately and load_ready to 1; a following load of 8'hFF, len=8 sends 8 ones.
- Hold load_valid=1 with changing load_data throughout a frame -> only the first word is sent; the second word is accepted only once load_ready returns.
